rv32i_cpu: RTL and testbench

//  Single-cycle RV32I integer core: top-level processor of the rv32i project.

---
 rtl/rv32i_pkg.sv | 72 +++++++
 rtl/rv32i_alu.sv | 30 +++
 rtl/rv32i_cpu.sv | 183 ++++++++++++++++++
 tb/tb_rv32i_cpu.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared encodings for the rv32i core: opcodes, funct3 codes and the ALU operation set.
// Also holds the funct3/funct7 to ALU-op mapping used by the decoder.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    // instr[30] selects SUB only for register ops; for immediates it is an imm bit except on shifts.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SRL:  op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// 32-bit integer ALU for the rv32i core; purely combinational.
// Shifts use only the low five bits of operand b.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_e     i_alu_op,
    output logic [31:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_alu_op)
            ALU_ADD:    o_result = i_a + i_b;
            ALU_SUB:    o_result = i_a - i_b;
            ALU_SLL:    o_result = i_a << i_b[4:0];
            ALU_SLT:    o_result = {31'b0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU:   o_result = {31'b0, i_a < i_b};
            ALU_XOR:    o_result = i_a ^ i_b;
            ALU_SRL:    o_result = i_a >> i_b[4:0];
            ALU_SRA:    o_result = $signed(i_a) >>> i_b[4:0];
            ALU_OR:     o_result = i_a | i_b;
            ALU_AND:    o_result = i_a & i_b;
            ALU_PASS_B: o_result = i_b;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_cpu.sv
// Single-cycle RV32I core: one instruction commits per rising edge.
// Instruction ROM contents come from IMEM_INIT; pc, regs[] and dmem[] are observed hierarchically.
module rv32i_cpu
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] IMEM_INIT [IMEM_DEPTH] = '{default: 32'h0000_0013}
) (
    input logic clk,
    input logic reset
);

    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    logic [31:0] pc;
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [31:0]   w_instr;
    logic [6:0]    w_opcode;
    logic [4:0]    w_rd, w_rs1, w_rs2;
    logic [2:0]    w_funct3;
    logic [31:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0]   w_rs1_val, w_rs2_val;
    logic [31:0]   w_alu_a, w_alu_b, w_alu_res;
    alu_op_e       w_alu_op;
    logic [31:0]   w_pc_plus4, w_next_pc, w_wb_data;
    logic          w_rd_we, w_br_taken;
    logic [DA-1:0] w_dmem_idx;
    logic [31:0]   w_dmem_rdata, w_load_data, w_store_data;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_store_be;

    assign w_instr  = IMEM_INIT[pc[IA+1:2]];
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    assign w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : regs[w_rs1];
    assign w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : regs[w_rs2];
    assign w_pc_plus4 = pc + 32'd4;

    rv32i_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_alu_op (w_alu_op),
        .o_result (w_alu_res)
    );

    always_comb begin
        w_br_taken = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_br_taken = (w_rs1_val == w_rs2_val);
            F3_BNE:  w_br_taken = (w_rs1_val != w_rs2_val);
            F3_BLT:  w_br_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
            F3_BGE:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            F3_BLTU: w_br_taken = (w_rs1_val < w_rs2_val);
            F3_BGEU: w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    // Load/store address is always the ALU sum rs1 + imm.
    assign w_dmem_idx   = w_alu_res[DA+1:2];
    assign w_dmem_rdata = dmem[w_dmem_idx];
    assign w_byte       = w_dmem_rdata[{w_alu_res[1:0], 3'b000} +: 8];
    assign w_half       = w_alu_res[1] ? w_dmem_rdata[31:16] : w_dmem_rdata[15:0];

    always_comb begin
        w_load_data = w_dmem_rdata;
        case (w_funct3)
            F3_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            F3_LW:   w_load_data = w_dmem_rdata;
            F3_LBU:  w_load_data = {24'b0, w_byte};
            F3_LHU:  w_load_data = {16'b0, w_half};
            default: w_load_data = w_dmem_rdata;
        endcase
    end

    always_comb begin
        w_alu_a      = w_rs1_val;
        w_alu_b      = w_imm_i;
        w_alu_op     = ALU_ADD;
        w_rd_we      = 1'b0;
        w_wb_data    = w_alu_res;
        w_next_pc    = w_pc_plus4;
        w_store_be   = 4'b0000;
        w_store_data = w_rs2_val;
        case (w_opcode)
            OP_LUI: begin
                w_alu_op = ALU_PASS_B;
                w_alu_b  = w_imm_u;
                w_rd_we  = 1'b1;
            end
            OP_AUIPC: begin
                w_alu_a = pc;
                w_alu_b = w_imm_u;
                w_rd_we = 1'b1;
            end
            OP_JAL: begin
                w_rd_we   = 1'b1;
                w_wb_data = w_pc_plus4;
                w_next_pc = pc + w_imm_j;
            end
            OP_JALR: begin
                w_rd_we   = 1'b1;
                w_wb_data = w_pc_plus4;
                w_next_pc = w_alu_res & ~32'd1;
            end
            OP_BRANCH: begin
                if (w_br_taken) w_next_pc = pc + w_imm_b;
            end
            OP_LOAD: begin
                w_rd_we   = 1'b1;
                w_wb_data = w_load_data;
            end
            OP_STORE: begin
                w_alu_b = w_imm_s;
                case (w_funct3)
                    F3_SB: begin
                        w_store_be   = 4'b0001 << w_alu_res[1:0];
                        w_store_data = {4{w_rs2_val[7:0]}};
                    end
                    F3_SH: begin
                        w_store_be   = w_alu_res[1] ? 4'b1100 : 4'b0011;
                        w_store_data = {2{w_rs2_val[15:0]}};
                    end
                    F3_SW:   w_store_be = 4'b1111;
                    default: w_store_be = 4'b0000;
                endcase
            end
            OP_IMM: begin
                w_alu_op = alu_decode(w_funct3, w_instr[30], 1'b0);
                w_rd_we  = 1'b1;
            end
            OP_REG: begin
                w_alu_b  = w_rs2_val;
                w_alu_op = alu_decode(w_funct3, w_instr[30], 1'b1);
                w_rd_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (w_rd_we && (w_rd != 5'd0)) begin
            regs[w_rd] <= w_wb_data;
        end
    end

    // Data RAM keeps its contents through reset; stores are only blocked while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                if (w_store_be[b]) dmem[w_dmem_idx][8*b +: 8] <= w_store_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_rv32i_cpu.sv
// Self-checking bench for rv32i_cpu: runs a fixed program step by step against a table of
// expected per-instruction results, then exercises asynchronous reset mid-run.
module tb_rv32i_cpu;

    localparam logic [31:0] PROG [256] = '{
        0:  32'h00500093,  // addi x1,x0,5
        1:  32'hFFD00113,  // addi x2,x0,-3
        2:  32'h002081B3,  // add  x3,x1,x2
        3:  32'h40110233,  // sub  x4,x2,x1
        4:  32'hF8000293,  // addi x5,x0,-128
        5:  32'h005000A3,  // sb   x5,1(x0)
        6:  32'h00100303,  // lb   x6,1(x0)
        7:  32'h00104383,  // lbu  x7,1(x0)
        8:  32'h00000463,  // beq  x0,x0,+8
        9:  32'h00100493,  // addi x9,x0,1 (skipped)
        10: 32'h00C000EF,  // jal  x1,+12
        11: 32'h00700013,  // addi x0,x0,7
        12: 32'h0100006F,  // jal  x0,+16
        13: 32'h00008067,  // jalr x0,0(x1)
        16: 32'h80000437,  // lui  x8,0x80000
        17: 32'h41F45413,  // srai x8,x8,31
        18: 32'h00401323,  // sh   x4,6(x0)
        19: 32'h00605603,  // lhu  x12,6(x0)
        20: 32'h00601683,  // lh   x13,6(x0)
        21: 32'h00302423,  // sw   x3,8(x0)
        22: 32'h00802703,  // lw   x14,8(x0)
        23: 32'h00731463,  // bne  x6,x7,+8
        24: 32'h00200493,  // addi x9,x0,2 (skipped)
        25: 32'h00734463,  // blt  x6,x7,+8
        26: 32'h00300493,  // addi x9,x0,3 (skipped)
        27: 32'h00736463,  // bltu x6,x7,+8 (not taken)
        28: 32'h0063B7B3,  // sltu x15,x7,x6
        29: 32'h00732833,  // slt  x16,x6,x7
        30: 32'h00001897,  // auipc x17,0x1
        31: 32'h00000073,  // ecall
        32: 32'hFFF0C913,  // xori x18,x1,-1
        33: 32'h002099B3,  // sll  x19,x1,x2
        34: 32'h0029DA33,  // srl  x20,x19,x2
        35: 32'h0F097A93,  // andi x21,x18,0xF0
        36: 32'h0063D463,  // bge  x7,x6,+8
        37: 32'h00400493,  // addi x9,x0,4 (skipped)
        38: 32'h0000006F,  // jal  x0,0
        default: 32'h00000013
    };

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        is_mem;
        int          idx;
        logic [31:0] val;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs[$];
    logic [31:0] exp_q[$];

    rv32i_cpu #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (256),
        .IMEM_INIT  (PROG)
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] pc, input logic [31:0] npc, input logic is_mem,
                       input int idx, input logic [31:0] val);
        vec_t v;
        v.pc = pc; v.npc = npc; v.is_mem = is_mem; v.idx = idx; v.val = val;
        vecs.push_back(v);
    endtask

    // driver: advance one instruction, scoreboard the committed result
    task automatic step_and_check(input string name, input logic [31:0] exp_pc_after,
                                  input logic is_mem, input int idx, input logic [31:0] exp_val);
        logic [31:0] act;
        exp_q.push_back(exp_val);
        @(posedge clk);
        #1;
        act = is_mem ? dut.dmem[idx] : dut.regs[idx];
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            check(name, act, exp_q.pop_front());
        end
        check({name, "_pc"}, dut.pc, exp_pc_after);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        add(32'd0,   32'd4,   1'b0, 1,  32'h0000_0005);
        add(32'd4,   32'd8,   1'b0, 2,  32'hFFFF_FFFD);
        add(32'd8,   32'd12,  1'b0, 3,  32'h0000_0002);
        add(32'd12,  32'd16,  1'b0, 4,  32'hFFFF_FFF8);
        add(32'd16,  32'd20,  1'b0, 5,  32'hFFFF_FF80);
        add(32'd20,  32'd24,  1'b1, 0,  32'h0000_8000);
        add(32'd24,  32'd28,  1'b0, 6,  32'hFFFF_FF80);
        add(32'd28,  32'd32,  1'b0, 7,  32'h0000_0080);
        add(32'd32,  32'd40,  1'b0, 9,  32'h0000_0000);
        add(32'd40,  32'd52,  1'b0, 1,  32'h0000_002C);
        add(32'd52,  32'd44,  1'b0, 0,  32'h0000_0000);
        add(32'd44,  32'd48,  1'b0, 0,  32'h0000_0000);
        add(32'd48,  32'd64,  1'b0, 0,  32'h0000_0000);
        add(32'd64,  32'd68,  1'b0, 8,  32'h8000_0000);
        add(32'd68,  32'd72,  1'b0, 8,  32'hFFFF_FFFF);
        add(32'd72,  32'd76,  1'b1, 1,  32'hFFF8_0000);
        add(32'd76,  32'd80,  1'b0, 12, 32'h0000_FFF8);
        add(32'd80,  32'd84,  1'b0, 13, 32'hFFFF_FFF8);
        add(32'd84,  32'd88,  1'b1, 2,  32'h0000_0002);
        add(32'd88,  32'd92,  1'b0, 14, 32'h0000_0002);
        add(32'd92,  32'd100, 1'b0, 9,  32'h0000_0000);
        add(32'd100, 32'd108, 1'b0, 9,  32'h0000_0000);
        add(32'd108, 32'd112, 1'b0, 9,  32'h0000_0000);
        add(32'd112, 32'd116, 1'b0, 15, 32'h0000_0001);
        add(32'd116, 32'd120, 1'b0, 16, 32'h0000_0001);
        add(32'd120, 32'd124, 1'b0, 17, 32'h0000_1078);
        add(32'd124, 32'd128, 1'b0, 0,  32'h0000_0000);
        add(32'd128, 32'd132, 1'b0, 18, 32'hFFFF_FFD3);
        add(32'd132, 32'd136, 1'b0, 19, 32'h8000_0000);
        add(32'd136, 32'd140, 1'b0, 20, 32'h0000_0004);
        add(32'd140, 32'd144, 1'b0, 21, 32'h0000_00D0);
        add(32'd144, 32'd152, 1'b0, 9,  32'h0000_0000);
        add(32'd152, 32'd152, 1'b0, 9,  32'h0000_0000);

        // reset held for 100 ns
        reset = 1'b0;
        #100;
        check("reset_pc", dut.pc, 32'h0);
        for (int i = 1; i < 32; i++) check($sformatf("reset_x%0d", i), dut.regs[i], 32'h0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_pc", dut.pc, 32'h0);

        foreach (vecs[k]) begin
            check($sformatf("fetch_pc_%0d", k), dut.pc, vecs[k].pc);
            step_and_check($sformatf("step_%0d", k), vecs[k].npc, vecs[k].is_mem,
                           vecs[k].idx, vecs[k].val);
        end

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pc", dut.pc, 32'h0);
        check("async_rst_x1", dut.regs[1], 32'h0);
        check("async_rst_x21", dut.regs[21], 32'h0);
        check("async_rst_dmem2", dut.dmem[2], 32'h0000_0002);
        @(posedge clk);
        #1;
        check("held_rst_pc", dut.pc, 32'h0);
        check("held_rst_x1", dut.regs[1], 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rerelease_pc", dut.pc, 32'h0);
        step_and_check("restart_0", 32'd4, 1'b0, 1, 32'h0000_0005);
        step_and_check("restart_1", 32'd8, 1'b0, 2, 32'hFFFF_FFFD);

        check("sb_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
